// File: rtl/matrix_run_controller_if.sv
// rtl/matrix_run_controller_if.sv - engine and display handshake bundle for matrix_run_controller
//
// Purpose: groups the sequencer's handshakes with the three compute engines
//   and the display block into one bundle.
// Signals:
//   start_PE, start_3x3, start_2x2  sequencer -> engine, 1-cycle start pulses
//   done_PE, done_3x3, done_2x2     engine -> sequencer, finished (pulse or level)
//   run_display                     sequencer -> display, level for the whole display phase
//   state_display_i[2:0]            display -> sequencer, display sub-state (4 = done)
// Modports: master = sequencer side, slave = engine/display side.

interface matrix_run_controller_if;
  logic       start_PE;
  logic       done_PE;
  logic       start_3x3;
  logic       done_3x3;
  logic       start_2x2;
  logic       done_2x2;
  logic       run_display;
  logic [2:0] state_display_i;

  modport master (
    output start_PE, start_3x3, start_2x2, run_display,
    input  done_PE, done_3x3, done_2x2, state_display_i
  );

  modport slave (
    input  start_PE, start_3x3, start_2x2, run_display,
    output done_PE, done_3x3, done_2x2, state_display_i
  );
endinterface

// File: rtl/matrix_run_controller.sv
// rtl/matrix_run_controller.sv - one-at-a-time sequencer for the PE, 3x3, 2x2 engines and display
//
// Purpose: runs the PE, 3x3 and 2x2 engines strictly in sequence (they share the
//   operand memory), then holds run_display until the display block reports done.
//   Every wait is supervised by a timeout; the run length is reported on cycles_o.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        begin a run (sampled only in IDLE)
//   abort        return to IDLE from any state, clears ERROR
//   eng          engine/display handshake bundle (master side)
//   busy_o       high in every state except IDLE
//   done_o       1-cycle pulse on successful completion
//   error_o      high while in ERROR
//   err_stage_o  failing stage: 1=PE, 2=3x3, 3=2x2, 0=display
//   state_o      current FSM state encoding
//   cycles_o     cycles from start accept to done, saturating

module matrix_run_controller #(
  parameter int ENG_TIMEOUT  = 256,
  parameter int DISP_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  matrix_run_controller_if.master eng,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [1:0]              err_stage_o,
  output logic [3:0]              state_o,
  output logic [CNT_W-1:0]        cycles_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RUN_PE   = 4'd1,
    S_WAIT_PE  = 4'd2,
    S_RUN_3X3  = 4'd3,
    S_WAIT_3X3 = 4'd4,
    S_RUN_2X2  = 4'd5,
    S_WAIT_2X2 = 4'd6,
    S_DISPLAY  = 4'd7,
    S_DONE     = 4'd8,
    S_ERROR    = 4'd9
  } state_t;

  // One shared timeout counter serves every timed state, so it is sized for the longer limit.
  localparam int TMO_MAX = (ENG_TIMEOUT > DISP_TIMEOUT) ? ENG_TIMEOUT : DISP_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX);
  localparam logic [TMO_W-1:0] ENG_LAST  = TMO_W'(ENG_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] DISP_LAST = TMO_W'(DISP_TIMEOUT - 1);
  localparam logic [2:0]       DISP_DONE = 3'd4;

  state_t           state_q, state_d;
  logic [1:0]       err_q, err_d;
  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] cycles_q;
  logic             timed;
  logic             counting;

  assign timed    = (state_q == S_WAIT_PE) || (state_q == S_WAIT_3X3) ||
                    (state_q == S_WAIT_2X2) || (state_q == S_DISPLAY);
  assign counting = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

  // Next-state logic. In each WAIT/DISPLAY state the done test comes first,
  // so a done arriving on the final timeout cycle still wins.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_RUN_PE;
      S_RUN_PE:   state_d = S_WAIT_PE;
      S_WAIT_PE: begin
        if (eng.done_PE)            state_d = S_RUN_3X3;
        else if (tmo_q == ENG_LAST) begin state_d = S_ERROR; err_d = 2'd1; end
      end
      S_RUN_3X3:  state_d = S_WAIT_3X3;
      S_WAIT_3X3: begin
        if (eng.done_3x3)           state_d = S_RUN_2X2;
        else if (tmo_q == ENG_LAST) begin state_d = S_ERROR; err_d = 2'd2; end
      end
      S_RUN_2X2:  state_d = S_WAIT_2X2;
      S_WAIT_2X2: begin
        if (eng.done_2x2)           state_d = S_DISPLAY;
        else if (tmo_q == ENG_LAST) begin state_d = S_ERROR; err_d = 2'd3; end
      end
      S_DISPLAY: begin
        if (eng.state_display_i == DISP_DONE) state_d = S_DONE;
        else if (tmo_q == DISP_LAST)          begin state_d = S_ERROR; err_d = 2'd0; end
      end
      S_DONE:     state_d = S_IDLE;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_IDLE;
    endcase
    // abort overrides start, every done and the ERROR hold.
    if (abort) begin
      state_d = S_IDLE;
      err_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Timeout counter restarts on every state change, so each WAIT/DISPLAY entry begins at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (!timed || (state_d != state_q)) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Run-length counter: cleared on start accept, counts RUN_PE..DISPLAY, saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles_q <= '0;
    end else if ((state_q == S_IDLE) && (state_d == S_RUN_PE)) begin
      cycles_q <= '0;
    end else if (counting && (cycles_q != {CNT_W{1'b1}})) begin
      cycles_q <= cycles_q + CNT_W'(1);
    end
  end

  // Outputs are flopped from the next state so they line up with state_q without decode glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng.start_PE    <= 1'b0;
      eng.start_3x3   <= 1'b0;
      eng.start_2x2   <= 1'b0;
      eng.run_display <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
    end else begin
      eng.start_PE    <= (state_d == S_RUN_PE);
      eng.start_3x3   <= (state_d == S_RUN_3X3);
      eng.start_2x2   <= (state_d == S_RUN_2X2);
      eng.run_display <= (state_d == S_DISPLAY);
      busy_o          <= (state_d != S_IDLE);
      done_o          <= (state_d == S_DONE);
      error_o         <= (state_d == S_ERROR);
    end
  end

  assign state_o     = state_q;
  assign err_stage_o = err_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_matrix_run_controller.sv
// tb/tb_matrix_run_controller.sv - directed self-checking bench for matrix_run_controller

module tb_matrix_run_controller;
  localparam int ENG_T  = 8;
  localparam int DISP_T = 16;
  localparam int CW     = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          busy_o, done_o, error_o;
  logic [1:0]    err_stage_o;
  logic [3:0]    state_o;
  logic [CW-1:0] cycles_o;

  matrix_run_controller_if bus ();

  matrix_run_controller #(
    .ENG_TIMEOUT (ENG_T),
    .DISP_TIMEOUT(DISP_T),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .eng        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .err_stage_o(err_stage_o),
    .state_o    (state_o),
    .cycles_o   (cycles_o)
  );

  always #5 clk = ~clk;

  // Engine/display responders: done_x 5 cycles after start_x, display done 14 cycles after rise.
  bit         en_pe = 1, en_3 = 1, en_2 = 1, en_d = 1;
  logic       m_pe = 0, m_3 = 0, m_2 = 0;
  logic       d_pe = 0, d_3 = 0, d_2 = 0;
  logic [2:0] m_disp = 3'd0;
  int         pcnt = 0, c3 = 0, c2 = 0, dcnt = 0;
  logic       rd_prev = 0;
  int         starts_q[$];
  int         n_done = 0;
  int         multi = 0;

  assign bus.done_PE         = m_pe | d_pe;
  assign bus.done_3x3        = m_3 | d_3;
  assign bus.done_2x2        = m_2 | d_2;
  assign bus.state_display_i = m_disp;

  always begin
    @(posedge clk);
    #1;
    m_pe = 0; m_3 = 0; m_2 = 0;
    if (pcnt > 0) begin pcnt--; if (pcnt == 0) m_pe = 1; end
    if (c3 > 0)   begin c3--;   if (c3 == 0)   m_3 = 1;  end
    if (c2 > 0)   begin c2--;   if (c2 == 0)   m_2 = 1;  end
    if (bus.start_PE  && en_pe) pcnt = 5;
    if (bus.start_3x3 && en_3)  c3 = 5;
    if (bus.start_2x2 && en_2)  c2 = 5;
    if (!bus.run_display) begin
      dcnt = 0; m_disp = 3'd0;
    end else if (!rd_prev) begin
      if (en_d) dcnt = 14;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) m_disp = 3'd4;
    end
    rd_prev = bus.run_display;
    if (bus.start_PE)  starts_q.push_back(1);
    if (bus.start_3x3) starts_q.push_back(2);
    if (bus.start_2x2) starts_q.push_back(3);
    if ((int'(bus.start_PE) + int'(bus.start_3x3) + int'(bus.start_2x2)) > 1) multi++;
    if (done_o) n_done++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int budget, output int waited);
    waited = 0;
    while (state_o !== s && waited < budget) begin
      tick();
      waited++;
    end
    if (state_o !== s) check(tag, state_o, s);
  endtask

  task automatic wait_error(input int budget, output int waited);
    waited = 0;
    while (error_o !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  task automatic cleanup();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    en_pe = 1; en_3 = 1; en_2 = 1; en_d = 1;
    d_pe = 0; d_3 = 0; d_2 = 0;
    repeat (12) tick();
  endtask

  function automatic int seq_code();
    int s = 0;
    foreach (starts_q[i]) s = s * 10 + starts_q[i];
    return s;
  endfunction

  int w, k;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    check("rst_state",  state_o, 4'd0);
    check("rst_flags",  {busy_o, done_o, error_o, err_stage_o}, 5'd0);
    check("rst_starts", {bus.start_PE, bus.start_3x3, bus.start_2x2, bus.run_display}, 4'd0);
    check("rst_cycles", cycles_o, 5'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Nominal run: 3 x (1 RUN + 5 WAIT) + 15 DISPLAY = 33 cycles; cycles_o saturates at 31.
    starts_q.delete(); n_done = 0;
    pulse_start();
    check("nom_run_pe", {state_o, bus.start_PE}, {4'd1, 1'b1});
    wait_state("nom_to_done", 4'd8, 100, w);
    check("nom_len",    w, 33);
    check("nom_done",   {done_o, busy_o}, 2'b11);
    check("nom_sat",    cycles_o, 5'd31);
    tick();
    check("nom_idle",   {state_o, done_o, busy_o}, {4'd0, 1'b0, 1'b0});
    check("nom_hold",   cycles_o, 5'd31);
    check("nom_order",  seq_code(), 123);
    check("nom_ndone",  n_done, 1);
    repeat (4) tick();

    // start held high for the whole run: no restart, one start_PE.
    starts_q.delete(); n_done = 0;
    start = 1'b1;
    tick();
    k = 0;
    while (done_o !== 1'b1 && k < 100) begin tick(); k++; end
    start = 1'b0;
    check("hold_done_seen", done_o, 1'b1);
    repeat (2) tick();
    check("hold_idle",  state_o, 4'd0);
    check("hold_order", seq_code(), 123);
    check("hold_ndone", n_done, 1);

    // 3x3 never answers: ERROR after 8 WAIT_3x3 cycles, stage 2.
    en_3 = 0; starts_q.delete();
    pulse_start();
    wait_state("tmo_to_w3", 4'd4, 50, w);
    wait_error(30, k);
    check("tmo3_len",   k, 8);
    check("tmo3_state", {state_o, err_stage_o}, {4'd9, 2'd2});
    check("tmo3_cyc",   cycles_o, 5'd15);
    repeat (3) tick();
    check("tmo3_stay",  {error_o, bus.start_2x2, bus.run_display}, 3'b100);
    check("tmo3_order", seq_code(), 12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("tmo3_abort", {state_o, error_o, err_stage_o, busy_o}, {4'd0, 1'b0, 2'd0, 1'b0});
    cleanup();

    // done_PE on the last timeout cycle wins over the timeout.
    en_pe = 0;
    pulse_start();
    tick();
    check("bnd_wait0", state_o, 4'd2);
    repeat (ENG_T - 1) tick();
    check("bnd_last",  {state_o, error_o}, {4'd2, 1'b0});
    d_pe = 1'b1;
    tick();
    d_pe = 1'b0;
    check("bnd_go3x3", {state_o, error_o, bus.start_3x3}, {4'd3, 1'b0, 1'b1});
    cleanup();

    // done_PE during RUN_PE is ignored; WAIT_PE then times out with stage 1.
    en_pe = 0;
    pulse_start();
    d_pe = 1'b1;
    tick();
    d_pe = 1'b0;
    check("early_ign", state_o, 4'd2);
    wait_error(30, k);
    check("early_len",   k, 8);
    check("early_stage", {state_o, err_stage_o}, {4'd9, 2'd1});
    check("early_cyc",   cycles_o, 5'd9);
    cleanup();

    // Abort during DISPLAY.
    n_done = 0;
    pulse_start();
    wait_state("ab_to_disp", 4'd7, 100, w);
    check("ab_rd_high", bus.run_display, 1'b1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle", {state_o, bus.run_display, done_o}, {4'd0, 1'b0, 1'b0});
    repeat (20) tick();
    check("ab_nodone", n_done, 0);
    cleanup();

    // Display never finishes: ERROR after 16 DISPLAY cycles, stage 0.
    en_d = 0;
    pulse_start();
    wait_state("dt_to_disp", 4'd7, 100, w);
    wait_error(40, k);
    check("dtmo_len",   k, 16);
    check("dtmo_state", {state_o, err_stage_o, bus.run_display}, {4'd9, 2'd0, 1'b0});
    cleanup();

    // Asynchronous reset in WAIT_2x2, then a clean run.
    en_2 = 0;
    pulse_start();
    wait_state("rs_to_w2", 4'd6, 100, w);
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    check("arst_state",  {state_o, busy_o, error_o, done_o}, 7'd0);
    check("arst_outs",   {bus.start_PE, bus.start_3x3, bus.start_2x2, bus.run_display}, 4'd0);
    check("arst_cycles", cycles_o, 5'd0);
    tick();
    reset = 1'b1;
    en_2 = 1;
    repeat (3) tick();
    starts_q.delete(); n_done = 0;
    pulse_start();
    wait_state("rs_rerun", 4'd8, 100, w);
    check("rerun_len",  w, 33);
    check("rerun_done", done_o, 1'b1);
    tick();
    check("rerun_order", seq_code(), 123);
    check("no_double_start", multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
